vigna_m_dispatch: RTL and testbench

- Issue/writeback stage directly upstream of vigna_m_ext, the multiply/divide coprocessor.
- Accepts one instruction plus its rs1/rs2 values from the core execute stage and decodes RV32M.
- Drives the coprocessor valid/ready handshake, holding all operands stable for the whole operation, then presents the result on a writeback handshake.
- Handles pipeline flush, illegal (non-M) instructions and an optional zero-operand multiply bypass.

---
 rtl/vigna_m_pkg.sv | 25 ++
 rtl/vigna_m_dispatch.sv | 150 +++++++++++++++
 tb/tb_vigna_m_dispatch.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vigna_m_pkg.sv
// Shared decode constants and state encoding for the RV32M dispatch stage.
package vigna_m_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  function automatic logic is_rv32m(input logic [31:0] instr);
    return (instr[6:0] == OPC_OP) && (instr[31:25] == F7_MULDIV);
  endfunction

endpackage

// File: rtl/vigna_m_dispatch.sv
// RV32M issue/writeback stage in front of the vigna_m_ext coprocessor.
// Holds operands stable for the whole coprocessor operation and offers the
// result on a writeback handshake; handles flush, illegal ops and the
// zero-operand multiply bypass.
module vigna_m_dispatch
  import vigna_m_pkg::*;
#(
  parameter int unsigned ZERO_BYPASS = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [2:0]  in_tag,
  input  logic        flush,
  output logic        cp_valid,
  input  logic        cp_ready,
  output logic [2:0]  cp_func,
  output logic [2:0]  cp_id,
  output logic [31:0] cp_op1,
  output logic [31:0] cp_op2,
  input  logic [31:0] cp_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [2:0]  wb_tag,
  output logic        illegal,
  output logic        busy
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  func_q, func_d;
  logic [2:0]  tag_q, tag_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        illegal_q, illegal_d;

  logic        dec_is_m;
  logic [2:0]  dec_func;
  logic [4:0]  dec_rd;
  logic        accept;
  logic        bypass_hit;
  logic        unused_instr_bits;

  assign dec_is_m          = is_rv32m(in_instr);
  assign dec_func          = in_instr[14:12];
  assign dec_rd            = in_instr[11:7];
  assign unused_instr_bits = ^in_instr[24:15];

  assign in_ready   = (state_q == S_IDLE) && !flush;
  assign accept     = in_valid && in_ready;
  // Multiplies (func[2]==0) with a zero operand have a known result of 0.
  assign bypass_hit = (ZERO_BYPASS != 0) && !dec_func[2] &&
                      ((in_rs1 == '0) || (in_rs2 == '0));

  // Next-state and holding-register update for the dispatch FSM.
  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    tag_d     = tag_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    rd_d      = rd_q;
    data_d    = data_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!dec_is_m) begin
            illegal_d = 1'b1;
          end else if (dec_rd != '0) begin
            func_d = dec_func;
            tag_d  = in_tag;
            op1_d  = in_rs1;
            op2_d  = in_rs2;
            rd_d   = dec_rd;
            if (bypass_hit) begin
              data_d  = '0;
              state_d = S_WB;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_ISSUE: begin
        if (cp_ready) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            data_d  = cp_result;
            state_d = S_WB;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      // The coprocessor cannot abort: wait out its completion, drop result.
      S_DRAIN: begin
        if (cp_ready) state_d = S_IDLE;
      end
      S_WB: begin
        if (wb_ready || flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and holding registers, cleared by the shared coprocessor reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      func_q    <= '0;
      tag_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      rd_q      <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      tag_q     <= tag_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
    end
  end

  assign cp_valid = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign wb_valid = (state_q == S_WB);
  assign busy     = (state_q != S_IDLE);
  assign illegal  = illegal_q;
  assign cp_func  = func_q;
  assign cp_id    = tag_q;
  assign cp_op1   = op1_q;
  assign cp_op2   = op2_q;
  assign wb_rd    = rd_q;
  assign wb_data  = data_q;
  assign wb_tag   = tag_q;

endmodule

// File: tb/tb_vigna_m_dispatch.sv
// Bench for vigna_m_dispatch: job-level reference model, coprocessor
// responder with RV32M arithmetic, directed scenarios and random traffic.
module tb_vigna_m_dispatch;
  import vigna_m_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0, in_valid0 = 1'b0;
  logic [31:0] in_instr = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_tag = '0;
  logic        flush = 1'b0;
  logic        cp_ready = 1'b0, cp_ready0 = 1'b0;
  logic [31:0] cp_result = '0, cp_result0 = '0;
  logic        wb_ready = 1'b0, wb_ready0 = 1'b0;

  logic        in_ready, cp_valid, wb_valid, illegal, busy;
  logic [2:0]  cp_func, cp_id, wb_tag;
  logic [31:0] cp_op1, cp_op2, wb_data;
  logic [4:0]  wb_rd;

  logic        in_ready0, cp_valid0, wb_valid0, illegal0, busy0;
  logic [2:0]  cp_func0, cp_id0, wb_tag0;
  logic [31:0] cp_op10, cp_op20, wb_data0;
  logic [4:0]  wb_rd0;

  always #5 clk = ~clk;

  vigna_m_dispatch #(.ZERO_BYPASS(1)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .flush(flush), .cp_valid(cp_valid), .cp_ready(cp_ready), .cp_func(cp_func),
    .cp_id(cp_id), .cp_op1(cp_op1), .cp_op2(cp_op2), .cp_result(cp_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_tag(wb_tag), .illegal(illegal), .busy(busy)
  );

  vigna_m_dispatch #(.ZERO_BYPASS(0)) dut0 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .flush(flush), .cp_valid(cp_valid0), .cp_ready(cp_ready0), .cp_func(cp_func0),
    .cp_id(cp_id0), .cp_op1(cp_op10), .cp_op2(cp_op20), .cp_result(cp_result0),
    .wb_valid(wb_valid0), .wb_ready(wb_ready0), .wb_rd(wb_rd0), .wb_data(wb_data0),
    .wb_tag(wb_tag0), .illegal(illegal0), .busy(busy0)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model: one outstanding job at most
  bit          m_job, m_done, m_killed, m_illegal;
  logic [2:0]  m_func, m_tag;
  logic [4:0]  m_rd;
  logic [31:0] m_op1, m_op2, m_data;

  // coprocessor responder
  bit cop_busy;
  int cop_cnt;
  int cop_lat = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rv32m(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'b0, a};
    zb = {32'b0, b};
    case (f)
      F_MUL:    begin p = za * zb; return p[31:0];  end
      F_MULH:   begin p = sa * sb; return p[63:32]; end
      F_MULHSU: begin p = sa * zb; return p[63:32]; end
      F_MULHU:  begin p = za * zb; return p[63:32]; end
      F_DIV: begin
        if (b == '0) return '1;
        if (a == 32'h8000_0000 && b == '1) return a;
        return $signed(a) / $signed(b);
      end
      F_DIVU:   return (b == '0) ? '1 : a / b;
      F_REM: begin
        if (b == '0) return a;
        if (a == 32'h8000_0000 && b == '1) return '0;
        return $signed(a) % $signed(b);
      end
      default:  return (b == '0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] mkm(input logic [2:0] f, input logic [4:0] rd);
    return {7'h01, 5'd2, 5'd1, f, rd, 7'h33};
  endfunction

  function automatic logic [31:0] rand_instr();
    int r;
    logic [4:0] rd;
    r  = $urandom_range(0, 9);
    rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    if (r < 7)       return mkm(3'($urandom_range(0, 7)), rd);
    else if (r == 7) return {7'h00, 5'd2, 5'd1, 3'($urandom_range(0, 7)), rd, 7'h33};
    else if (r == 8) return {7'h01, 5'd2, 5'd1, 3'd0, rd, 7'h13};
    else             return $urandom;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    m_job = 0; m_done = 0; m_killed = 0; m_illegal = 0;
    cop_busy = 0; cop_cnt = 0;
    cp_ready = 1'b0;
  endtask

  // outputs expected from the current job
  task automatic check_cycle();
    chk("busy", 32'(busy), 32'(m_job));
    chk("cp_valid", 32'(cp_valid), 32'(m_job && !m_done));
    chk("wb_valid", 32'(wb_valid), 32'(m_job && m_done));
    chk("illegal", 32'(illegal), 32'(m_illegal));
    if (m_job && !m_done) begin
      chk("cp_func", 32'(cp_func), 32'(m_func));
      chk("cp_id", 32'(cp_id), 32'(m_tag));
      chk("cp_op1", cp_op1, m_op1);
      chk("cp_op2", cp_op2, m_op2);
    end
    if (m_job && m_done) begin
      chk("wb_rd", 32'(wb_rd), 32'(m_rd));
      chk("wb_tag", 32'(wb_tag), 32'(m_tag));
      chk("wb_data", wb_data, m_data);
    end
  endtask

  task automatic cop_fire();
    cp_ready  = 1'b1;
    cp_result = rv32m(cp_func, cp_op1, cp_op2);
    cop_busy  = 0;
  endtask

  task automatic cop_step();
    if (cp_ready) begin
      cp_ready  = 1'b0;
      cp_result = $urandom;
    end else if (cop_busy) begin
      if (cop_cnt == 0) cop_fire();
      else cop_cnt--;
    end else if (cp_valid) begin
      cop_busy = 1;
      cop_cnt  = (cop_lat < 0) ? int'($urandom_range(0, 3)) : cop_lat;
      if (cop_cnt == 0) cop_fire();
      else cop_cnt--;
    end
  endtask

  // job-level consequences of the inputs presented at the coming edge
  task automatic model_edge();
    bit acc;
    acc = in_valid && !m_job && !flush;
    m_illegal = 0;
    if (m_job) begin
      if (!m_done && !m_killed) begin
        if (cp_ready) begin
          if (flush) m_job = 0;
          else begin
            m_done = 1;
            m_data = rv32m(m_func, m_op1, m_op2);
          end
        end else if (flush) m_killed = 1;
      end else if (m_killed) begin
        if (cp_ready) begin m_job = 0; m_killed = 0; end
      end else if (wb_ready || flush) begin
        m_job = 0;
      end
    end else if (acc) begin
      if (!(in_instr[6:0] == 7'h33 && in_instr[31:25] == 7'h01)) begin
        m_illegal = 1;
      end else if (in_instr[11:7] != 5'd0) begin
        m_job = 1; m_killed = 0;
        m_func = in_instr[14:12]; m_rd = in_instr[11:7]; m_tag = in_tag;
        m_op1 = in_rs1; m_op2 = in_rs2;
        if (!in_instr[14] && (in_rs1 == '0 || in_rs2 == '0)) begin
          m_done = 1; m_data = '0;
        end else begin
          m_done = 0;
        end
      end
    end
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [2:0] tg, input bit fl,
                      input bit wr);
    @(negedge clk);
    check_cycle();
    in_valid = v; in_instr = ins; in_rs1 = r1; in_rs2 = r2; in_tag = tg;
    flush = fl; wb_ready = wr;
    cop_step();
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_job && !fl));
    model_edge();
  endtask

  task automatic idle(input bit wr);
    step(0, '0, '0, '0, '0, 0, wr);
  endtask

  task automatic run_until_wb(input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      idle(0);
      @(posedge clk); #1;
      if (wb_valid) ok = 1;
    end
    n_chk++;
    if (!ok) begin n_err++; $display("FAIL wb_timeout: wb_valid never rose within %0d cycles", max); end
  endtask

  task automatic run_until_idle(input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      idle(0);
      @(posedge clk); #1;
      if (!busy) ok = 1;
    end
    n_chk++;
    if (!ok) begin n_err++; $display("FAIL idle_timeout: busy never fell within %0d cycles", max); end
  endtask

  task automatic m_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [2:0] tg, input logic [31:0] exp,
                      input string name);
    step(1, mkm(f, rd), a, b, tg, 0, 0);
    run_until_wb(20);
    chk({name, "_data"}, wb_data, exp);
    chk({name, "_rd"}, 32'(wb_rd), 32'(rd));
    chk({name, "_tag"}, 32'(wb_tag), 32'(tg));
    chk({name, "_cpv_after_ready"}, 32'(cp_valid), 32'd0);
    idle(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    model_reset();
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cp_valid", 32'(cp_valid), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_cp_op1", cp_op1, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);

    chk("pin_mul", rv32m(F_MUL, 32'd7, 32'd6), 32'd42);
    chk("pin_divu", rv32m(F_DIVU, 32'd100, 32'd7), 32'd14);
    chk("pin_rem", rv32m(F_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_div0", rv32m(F_DIV, 32'd5, 32'd0), 32'hFFFF_FFFF);
    chk("pin_mulhu", rv32m(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);

    @(negedge clk);
    resetn = 1'b1;

    cop_lat = 2;
    m_op(F_MUL, 32'd7, 32'd6, 5'd5, 3'd2, 32'd42, "mul");
    cop_lat = 1;
    m_op(F_DIVU, 32'd100, 32'd7, 5'd3, 3'd1, 32'd14, "divu");
    m_op(F_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 3'd6, 32'hFFFF_FFFF, "rem");
    m_op(F_DIV, 32'd5, 32'd0, 5'd31, 3'd7, 32'hFFFF_FFFF, "div0");

    // zero-operand multiply: bypassed here, issued on the non-bypass instance
    step(1, mkm(F_MUL, 5'd8), 32'd0, 32'd5, 3'd3, 0, 0);
    in_valid0 = 1'b1;
    @(posedge clk); #1;
    chk("byp_wb_valid", 32'(wb_valid), 32'd1);
    chk("byp_wb_data", wb_data, 32'd0);
    chk("nobyp_cp_valid", 32'(cp_valid0), 32'd1);
    in_valid0  = 1'b0;
    cp_ready0  = 1'b1;
    cp_result0 = rv32m(cp_func0, cp_op10, cp_op20);
    idle(1);
    @(posedge clk); #1;
    chk("nobyp_wb_valid", 32'(wb_valid0), 32'd1);
    chk("nobyp_wb_data", wb_data0, 32'd0);
    chk("nobyp_cpv_after", 32'(cp_valid0), 32'd0);
    cp_ready0 = 1'b0;
    wb_ready0 = 1'b1;

    // flush while the divide is in flight
    cop_lat = 6;
    step(1, mkm(F_DIV, 5'd7), 32'd100, 32'd3, 3'd4, 0, 0);
    idle(0);
    step(0, '0, '0, '0, '0, 1, 0);
    @(posedge clk); #1;
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_cp_valid", 32'(cp_valid), 32'd1);
    chk("drain_op1", cp_op1, 32'd100);
    chk("drain_op2", cp_op2, 32'd3);
    step(0, '0, '0, '0, '0, 1, 1);
    run_until_idle(20);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    chk("drain_no_wb", 32'(wb_valid), 32'd0);

    // illegal op and rd=0 discard
    step(1, {7'h00, 5'd2, 5'd1, 3'd0, 5'd9, 7'h33}, 32'd1, 32'd2, 3'd0, 0, 0);
    @(posedge clk); #1;
    chk("illegal_pulse", 32'(illegal), 32'd1);
    chk("illegal_no_busy", 32'(busy), 32'd0);
    idle(0);
    @(posedge clk); #1;
    chk("illegal_one_cycle", 32'(illegal), 32'd0);
    step(1, mkm(F_DIVU, 5'd0), 32'd9, 32'd3, 3'd0, 0, 0);
    @(posedge clk); #1;
    chk("rd0_no_busy", 32'(busy), 32'd0);
    chk("rd0_no_wb", 32'(wb_valid), 32'd0);

    // writeback stall: outputs stay put, nothing new accepted
    cop_lat = 0;
    step(1, mkm(F_MUL, 5'd9), 32'd3, 32'd4, 3'd1, 0, 0);
    run_until_wb(20);
    held = wb_data;
    for (int i = 0; i < 10; i++) step(1, mkm(F_MULHU, 5'd2), 32'd5, 32'd6, 3'd5, 0, 0);
    @(posedge clk); #1;
    chk("stall_wb_valid", 32'(wb_valid), 32'd1);
    chk("stall_wb_data", wb_data, 32'd12);
    chk("stall_data_held", wb_data, held);
    idle(1);

    // asynchronous reset in ISSUE
    cop_lat = 8;
    step(1, mkm(F_DIVU, 5'd6), 32'd77, 32'd5, 3'd2, 0, 0);
    idle(0);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_cp_valid", 32'(cp_valid), 32'd0);
    chk("areset_wb_valid", 32'(wb_valid), 32'd0);
    chk("areset_cp_op1", cp_op1, 32'd0);
    chk("areset_cp_func", 32'(cp_func), 32'd0);
    chk("areset_wb_tag", 32'(wb_tag), 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;

    // random traffic
    cop_lat = -1;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 6, rand_instr(), rand_val(), rand_val(),
           3'($urandom_range(0, 7)), $urandom_range(0, 11) == 0,
           1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    check_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
